// File: rtl/direction_queue_ctrl.sv
// Snake direction controller: decodes button pulses into a small turn FIFO drained by game_tick.
// Optional pause state is built in when DIR_PAUSE_EN is defined.
module direction_queue_ctrl #(
    parameter int         QUEUE_DEPTH = 2,
    parameter logic [1:0] INIT_DIR    = 2'b01
) (
    input  logic       clock_25,
    input  logic       reset,
    input  logic       btn_up,
    input  logic       btn_right,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       game_tick,
    input  logic       clear,
`ifdef DIR_PAUSE_EN
    input  logic       btn_pause,
`endif
    output logic [1:0] direction,
    output logic       dir_changed,
    output logic [2:0] pending,
    output logic       running
);

    localparam logic [1:0] S_WAIT_START = 2'd0;
    localparam logic [1:0] S_RUN        = 2'd1;
`ifdef DIR_PAUSE_EN
    localparam logic [1:0] S_PAUSE      = 2'd2;
`endif
    localparam logic [1:0] LAST_IDX = 2'(QUEUE_DEPTH - 1);
    localparam logic [2:0] FULL_CNT = 3'(QUEUE_DEPTH);

    logic [1:0] r_state;
    logic [1:0] r_fifo [0:3];
    logic [1:0] r_rd_ptr;
    logic [1:0] r_wr_ptr;
    logic [1:0] r_direction;
    logic [2:0] r_pending;
    logic       r_dir_changed;
    logic       r_running;

    logic       w_valid;
    logic [1:0] w_press_dir;
    logic [1:0] w_tail_idx;
    logic [1:0] w_ref_dir;
    logic       w_accept;
    logic       w_pause;
    logic       w_in_run;
    logic       w_start;
    logic       w_pop;
    logic       w_push;
    logic [1:0] w_state_nxt;

    function automatic logic [1:0] f_inc(input logic [1:0] p);
        return (p == LAST_IDX) ? 2'd0 : p + 2'd1;
    endfunction

    always_comb begin
        w_valid     = 1'b1;
        w_press_dir = 2'b00;
        case ({btn_up, btn_right, btn_down, btn_left})
            4'b1000: w_press_dir = 2'b00;
            4'b0100: w_press_dir = 2'b01;
            4'b0010: w_press_dir = 2'b10;
            4'b0001: w_press_dir = 2'b11;
            default: w_valid     = 1'b0;
        endcase
    end

`ifdef DIR_PAUSE_EN
    assign w_pause = btn_pause;
`else
    assign w_pause = 1'b0;
`endif

    // New presses are validated against the last queued turn, not the committed direction
    assign w_tail_idx = (r_wr_ptr == 2'd0) ? LAST_IDX : r_wr_ptr - 2'd1;
    assign w_ref_dir  = (r_pending != 3'd0) ? r_fifo[w_tail_idx] : r_direction;
    assign w_accept   = w_valid && (w_press_dir != w_ref_dir)
                        && (w_press_dir != (w_ref_dir ^ 2'b10));

    // A pause toggle owns its cycle: ticks and presses alongside it are ignored
    assign w_in_run = (r_state == S_RUN) && !w_pause;
    assign w_start  = (r_state == S_WAIT_START) && w_valid
                      && (w_press_dir != (INIT_DIR ^ 2'b10));
    assign w_pop    = w_in_run && game_tick && (r_pending != 3'd0);
    assign w_push   = w_in_run && w_accept && ((r_pending != FULL_CNT) || game_tick);

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_WAIT_START: if (w_start) w_state_nxt = S_RUN;
`ifdef DIR_PAUSE_EN
            S_RUN:        if (w_pause) w_state_nxt = S_PAUSE;
            S_PAUSE:      if (w_pause) w_state_nxt = S_RUN;
`else
            S_RUN:        w_state_nxt = S_RUN;
`endif
            default:      w_state_nxt = S_WAIT_START;
        endcase
        if (clear) w_state_nxt = S_WAIT_START;
    end

    always_ff @(posedge clock_25 or posedge reset) begin
        if (reset) begin
            r_state       <= S_WAIT_START;
            r_direction   <= INIT_DIR;
            r_pending     <= 3'd0;
            r_dir_changed <= 1'b0;
            r_running     <= 1'b0;
            r_rd_ptr      <= 2'd0;
            r_wr_ptr      <= 2'd0;
            for (int i = 0; i < 4; i++) r_fifo[i] <= INIT_DIR;
        end else begin
            r_state       <= w_state_nxt;
            r_running     <= (w_state_nxt == S_RUN);
            r_dir_changed <= 1'b0;
            if (clear) begin
                r_direction <= INIT_DIR;
                r_pending   <= 3'd0;
                r_rd_ptr    <= 2'd0;
                r_wr_ptr    <= 2'd0;
            end else begin
                if (w_start) begin
                    r_direction   <= w_press_dir;
                    r_dir_changed <= (w_press_dir != r_direction);
                end
                if (w_pop) begin
                    r_direction   <= r_fifo[r_rd_ptr];
                    r_dir_changed <= (r_fifo[r_rd_ptr] != r_direction);
                    r_rd_ptr      <= f_inc(r_rd_ptr);
                end
                if (w_push) begin
                    r_fifo[r_wr_ptr] <= w_press_dir;
                    r_wr_ptr         <= f_inc(r_wr_ptr);
                end
                r_pending <= r_pending + {2'b00, w_push} - {2'b00, w_pop};
            end
        end
    end

    assign direction   = r_direction;
    assign dir_changed = r_dir_changed;
    assign pending     = r_pending;
    assign running     = r_running;

endmodule
